// File: rtl/loop_fixpoint_solver.sv
// Clocked evaluator for an ordered feedback chain: one full sweep of STAGES
// operations per RUN cycle until the state vector stops changing or the budget runs out.
module loop_fixpoint_solver #(
   parameter int WIDTH    = 16,
   parameter int STAGES   = 3,
   parameter int MAX_ITER = 15,
   parameter int IW       = $clog2(MAX_ITER + 1)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_start,
   input  logic [STAGES*WIDTH-1:0]   i_data,
   input  logic [2*STAGES-1:0]       i_op,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_converged,
   output logic [IW-1:0]             o_iter,
   output logic [STAGES*WIDTH-1:0]   o_state
);

   localparam int            VW        = STAGES * WIDTH;
   localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t                fsm;
   fsm_t                fsm_next;
   logic [VW-1:0]       data_q;
   logic [2*STAGES-1:0] op_q;
   logic [VW-1:0]       state_q;
   logic [VW-1:0]       sweep;
   logic [IW-1:0]       iter_q;
   logic [IW-1:0]       iter_next;
   logic                conv_q;
   logic                fixed;

   function automatic logic [WIDTH-1:0] apply(input logic [1:0]       op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      case (op)
         2'b00:   apply = a ^ b;
         2'b01:   apply = a & b;
         2'b10:   apply = a | b;
         default: apply = a + b;
      endcase
   endfunction

   // Stage 0 is fed by the previous sweep's last stage; later stages see
   // the value just produced in this sweep, like a chain of blocking assigns.
   always_comb begin : sweep_chain
      logic [WIDTH-1:0] prev;
      prev  = state_q[(STAGES-1)*WIDTH +: WIDTH];
      sweep = '0;
      for (int k = 0; k < STAGES; k++) begin
         prev = apply(op_q[2*k +: 2], prev, data_q[k*WIDTH +: WIDTH]);
         sweep[k*WIDTH +: WIDTH] = prev;
      end
   end

   assign iter_next = iter_q + 1'b1;
   assign fixed     = (sweep == state_q);

   always_comb begin
      fsm_next = fsm;
      o_busy   = 1'b0;
      o_done   = 1'b0;
      case (fsm)
         IDLE: begin
            if (i_start) fsm_next = RUN;
         end
         RUN: begin
            o_busy = 1'b1;
            if (fixed || iter_next == ITER_LAST) fsm_next = DONE;
         end
         DONE: begin
            o_busy   = 1'b1;
            o_done   = 1'b1;
            fsm_next = IDLE;
         end
         default: fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fsm     <= IDLE;
         data_q  <= '0;
         op_q    <= '0;
         state_q <= '0;
         iter_q  <= '0;
         conv_q  <= 1'b0;
      end else begin
         fsm <= fsm_next;
         case (fsm)
            IDLE: begin
               if (i_start) begin
                  data_q  <= i_data;
                  op_q    <= i_op;
                  state_q <= '0;
                  iter_q  <= '0;
                  conv_q  <= 1'b0;
               end
            end
            RUN: begin
               state_q <= sweep;
               iter_q  <= iter_next;
               // Convergence takes precedence over budget exhaustion.
               if (fixed) conv_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_state     = state_q;
   assign o_iter      = iter_q;
   assign o_converged = conv_q;

endmodule

// File: tb/tb_loop_fixpoint_solver.sv
// Bench for loop_fixpoint_solver (WIDTH=16, STAGES=3, MAX_ITER=15): vector table
// of chains with hand-derived results, plus start-hold and mid-run reset sequences.
module tb_loop_fixpoint_solver;

   logic        i_clk;
   logic        i_rst;
   logic        i_start;
   logic [47:0] i_data;
   logic [5:0]  i_op;
   logic        o_busy;
   logic        o_done;
   logic        o_converged;
   logic [3:0]  o_iter;
   logic [47:0] o_state;

   loop_fixpoint_solver #(
      .WIDTH    (16),
      .STAGES   (3),
      .MAX_ITER (15)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_data      (i_data),
      .i_op        (i_op),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_converged (o_converged),
      .o_iter      (o_iter),
      .o_state     (o_state)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [5:0]  op;
      logic [47:0] data;
      logic        conv;
      logic [3:0]  iter;
      logic [47:0] state;
   } vec_t;

   vec_t        vecs[9];
   logic [52:0] exp_q[$];
   int          n_cmp;
   int          n_err;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard: pops one expected result when o_done shows up
   task automatic wait_done(input int n_exp);
      int          edges;
      logic [52:0] exp;
      edges = 1;
      while (o_done !== 1'b1 && edges < 40) begin
         @(posedge i_clk);
         #1;
         edges++;
      end
      check("done_seen", 64'(o_done), 64'(1));
      check("latency", 64'(edges), 64'(n_exp + 1));
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard: got done with empty expected queue");
      end else begin
         exp = exp_q.pop_front();
         check("result", 64'({o_converged, o_iter, o_state}), 64'(exp));
      end
   endtask

   // driver: one start pulse, inputs scrambled right after the latch edge
   task automatic run_vec(input vec_t v);
      @(negedge i_clk);
      i_op    = v.op;
      i_data  = v.data;
      i_start = 1'b1;
      exp_q.push_back({v.conv, v.iter, v.state});
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      i_data  = {16'($urandom), 32'($urandom)};
      i_op    = 6'($urandom_range(0, 63));
      check("start_busy", 64'(o_busy), 64'(1));
      check("start_clear", 64'({o_converged, o_iter, o_state}), 64'(0));
      wait_done(int'(v.iter));
      @(posedge i_clk);
      #1;
      check("idle_after", 64'({o_busy, o_done}), 64'(0));
      check("hold", 64'({o_converged, o_iter, o_state}), 64'({v.conv, v.iter, v.state}));
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      i_rst   = 1'b1;
      i_start = 1'b1;
      i_data  = 48'hFFFF_FFFF_FFFF;
      i_op    = 6'b111111;

      // op = {op2, op1, op0}, data = {d2, d1, d0}; 00 XOR 01 AND 10 OR 11 ADD
      vecs[0] = '{6'b00_00_00, 48'h0000_0000_0000, 1'b1, 4'd1,  48'h0000_0000_0000};
      vecs[1] = '{6'b00_01_00, 48'h0000_0000_00A5, 1'b1, 4'd2,  48'h0000_0000_00A5};
      vecs[2] = '{6'b00_00_00, 48'h0000_0000_0001, 1'b0, 4'd15, 48'h0001_0001_0001};
      vecs[3] = '{6'b00_01_10, 48'h0000_0001_0001, 1'b1, 4'd2,  48'h0001_0001_0001};
      vecs[4] = '{6'b00_01_10, 48'h0001_0001_0000, 1'b0, 4'd15, 48'h0001_0000_0000};
      vecs[5] = '{6'b00_00_11, 48'h0000_0000_FFFF, 1'b0, 4'd15, 48'hFFF1_FFF1_FFF1};
      vecs[6] = '{6'b01_10_10, 48'hFF00_00F0_1234, 1'b1, 4'd2,  48'h1200_12F4_1234};
      vecs[7] = '{6'b01_11_00, 48'h0000_8000_8000, 1'b1, 4'd2,  48'h0000_0000_8000};
      vecs[8] = '{6'b01_11_10, 48'hFFFF_0001_0001, 1'b0, 4'd15, 48'h001E_001E_001D};

      // reset overrides a held start
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_outputs", 64'({o_busy, o_done, o_converged, o_iter, o_state}), 64'(0));
      @(negedge i_clk);
      i_rst   = 1'b0;
      i_start = 1'b0;
      @(posedge i_clk);
      #1;
      check("idle_after_reset", 64'({o_busy, o_done}), 64'(0));

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // start held high through RUN and DONE: one run, next accepted in first IDLE cycle
      @(negedge i_clk);
      i_op    = vecs[1].op;
      i_data  = vecs[1].data;
      i_start = 1'b1;
      exp_q.push_back({vecs[1].conv, vecs[1].iter, vecs[1].state});
      @(posedge i_clk);
      #1;
      wait_done(2);
      @(posedge i_clk);
      #1;
      check("held_start_ignored_in_done", 64'(o_busy), 64'(0));
      exp_q.push_back({vecs[1].conv, vecs[1].iter, vecs[1].state});
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      check("held_start_reaccepted", 64'({o_busy, o_iter, o_converged}), 64'({1'b1, 4'd0, 1'b0}));
      wait_done(2);
      @(posedge i_clk);
      #1;
      check("held_idle_after", 64'({o_busy, o_done}), 64'(0));

      // reset pulsed after sweep 3 of an oscillating run
      @(negedge i_clk);
      i_op    = vecs[2].op;
      i_data  = vecs[2].data;
      i_start = 1'b1;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      check("mid_run_iter", 64'({o_busy, o_iter}), 64'({1'b1, 4'd3}));
      check("mid_run_state", 64'(o_state), 64'(48'h0001_0001_0001));
      @(negedge i_clk);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check("mid_run_reset", 64'({o_busy, o_done, o_converged, o_iter, o_state}), 64'(0));
      @(negedge i_clk);
      i_rst = 1'b0;
      run_vec(vecs[6]);
      run_vec(vecs[5]);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/loop_fixpoint_solver.md
# loop_fixpoint_solver

Sequential, parametrised evaluator for combinational feedback chains of the kind the scheduler fuzz modules build in a single `always_comb`. The chain runs as a clocked iteration: one full ordered sweep of `STAGES` operations per clock, until the state stops changing (fixed point) or an iteration budget runs out. Used as a golden model and stimulus block alongside the loop-style fuzz modules. It reports convergence, sweep count and the final stage values.

## Interface
- `WIDTH`, 16: bit width of each stage value.
- `STAGES`, 3: number of chained stages, ≥1.
- `MAX_ITER`, 15: sweep budget, ≥1.
- `IW`, `$clog2(MAX_ITER+1)`: derived width of the iteration count.

- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst`  in  1  reset; synchronous and active-high.
- `i_start`  in  1  request to run; accepted only in IDLE.
- `i_data`  in  `STAGES*WIDTH`  operand per stage; stage k is `[k*WIDTH +: WIDTH]`.
- `i_op`  in  `2*STAGES`  opcode per stage, `[2k +: 2]`: 00 XOR, 01 AND, 10 OR, 11 ADD (mod 2^WIDTH).
- `o_busy`  out  1  high in RUN and DONE.
- `o_done`  out  1  one-cycle pulse in DONE.
- `o_converged`  out  1  the last run reached a fixed point; held until the next accepted start.
- `o_iter`  out  `IW`  sweeps performed in the current or last run.
- `o_state`  out  `STAGES*WIDTH`  stage values; stage k is at `[k*WIDTH +: WIDTH]`.

## Operation
- **FSM states: IDLE, RUN, DONE.**
  - IDLE → RUN when `i_start` is high.
  - RUN → DONE when a sweep converges or `o_iter` reaches `MAX_ITER`.
  - DONE → IDLE always, after one cycle.
- **Start acceptance (in IDLE with `i_start`):**
  - `i_data` and `i_op` are latched.
  - `o_state`, `o_iter` and `o_converged` clear to 0.
  - Inputs are ignored after the latch edge.
- **Sweep (each RUN cycle, old = current `o_state`):**
  - `s0' = op0(old[STAGES-1], d0)`.
  - For k ≥ 1: `sk' = opk(s(k-1)', dk)`. These are in-sweep values, ordered like blocking assignments.
  - For `STAGES=1`: `s0' = op0(old s0, d0)`.
  - At the edge: `o_state <= s'` and `o_iter <= o_iter+1`.
- **Convergence:**
  - If `s' == old` (full vector compare), set `o_converged <= 1` and go to DONE.
  - Otherwise, if `o_iter+1 == MAX_ITER`, go to DONE with `o_converged = 0`.
  - If both hold in the same sweep, convergence wins and `o_converged = 1`.
- **ADD:** result is truncated to `WIDTH`; carry is discarded.
- **Start while busy:** `i_start` in RUN or DONE is ignored and not queued.
- **Reset:**
  - `i_rst` overrides everything, including mid-RUN.
  - Next state is IDLE.
  - All outputs are 0 and the latched inputs are 0.
- **Hold:** outputs hold their final values in IDLE until the next accepted start.

## Timing
- Start sampled at edge E0: `o_busy = 1` from E0.
- First sweep is committed at E1.
- A run of n sweeps ends in RUN at edge En. `o_done` is high for the single cycle after En, then the block is IDLE at E(n+1).
- Start-to-done latency: n+1 edges.
- Maximum latency: `MAX_ITER+1`.
- Back-to-back runs: the earliest next accepted start is the first IDLE cycle after DONE.
- `o_state` and `o_iter` update every RUN edge; intermediate values are visible.
- No combinational path from inputs to outputs.

## Test plan
- **Simple convergence.**
  - Setup: `STAGES=2, WIDTH=16`, ops {XOR, AND}, d0=0x00A5, d1=0x0000, start.
  - Sweep 1 gives s0=0x00A5, s1=0; sweep 2 repeats the same values.
  - Expect done with `o_converged=1`, `o_iter=2`, `o_state=0x0000_00A5`, `o_done` 3 edges after the start edge.
- **Oscillation exhausts budget.**
  - Setup: `STAGES=1`, XOR, d0=0x0001, `MAX_ITER=15`.
  - State toggles 0/1 every sweep.
  - Expect `o_converged=0`, `o_iter=15`, `o_state=0x0001`.
- **Three-stage chain, WIDTH=1.**
  - Ops {OR, AND, XOR}.
  - d={p=1, q=1, r=0}: expect converged, `o_iter=2`, `o_state=3'b111`.
  - d={p=0, q=1, r=1}: expect oscillation, `o_converged=0`, `o_iter=MAX_ITER`.
- **ADD wrap-around.**
  - Setup: `STAGES=1`, ADD, d0=0xFFFF, `MAX_ITER=15`.
  - Expect `o_state=0xFFF1`, `o_converged=0`, `o_iter=15`.
- **Immediate fixed point.**
  - Setup: all ops XOR, all data 0.
  - Expect `o_converged=1`, `o_iter=1`, done 2 edges after start.
- **Control robustness.**
  - `i_start` held high through RUN and DONE: exactly one run, then a new run begins from the first IDLE cycle.
  - `i_rst` pulsed at RUN sweep 3: next cycle all outputs 0 and IDLE; a following start produces correct results.
